// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan feeder.
package seg7_pkg;

  // Handshake sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STROBE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_NEXT
  } state_e;

  // Active-high patterns {dp,g,f,e,d,c,b,a} for hex digits 0..F.
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam int         DP_BIT  = 7;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high 7-segment pattern with decimal point.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  // Table lookup, overlay the decimal point, then blank overrides everything.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on entry, so no path can leave it unassigned and infer a latch.
    o_seg         = SEG_TABLE[i_nibble];
    o_seg[DP_BIT] = i_dp;
    if (i_blank) begin
      o_seg = SEG_OFF;
    end
  end

endmodule

// File: rtl/seg7_scan_feeder.sv
// Multiplexed hex display scanner: each refresh slot sends a segment byte then a
// one-hot digit-select byte to a 74HC595 driver over its en/rdy handshake.
module seg7_scan_feeder
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [4*N_DIGITS-1:0] i_value,
  input  logic [N_DIGITS-1:0]   i_dp_mask,
  input  logic                  i_blank,
  input  logic                  i_rdy,
  output logic [7:0]            o_data,
  output logic                  o_en,
  output logic                  o_frame_done,
  output logic                  o_busy
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int DIG_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(N_DIGITS - 1);
  localparam logic [7:0]       DIG_MASK = 8'((9'h1 << N_DIGITS) - 9'h1);

  state_e                state_q, state_d;
  logic                  byte_sel_q, byte_sel_d;
  logic [DIG_W-1:0]      digit_q, digit_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  pend_q, pend_d;
  logic [4*N_DIGITS-1:0] value_q, value_d;
  logic [N_DIGITS-1:0]   dp_q, dp_d;
  logic                  blank_q, blank_d;
  logic [7:0]            data_q, data_d;

  logic                  tick;
  logic                  snap_now;
  logic [4*N_DIGITS-1:0] value_src;
  logic [N_DIGITS-1:0]   dp_src;
  logic                  blank_src;
  logic [3:0]            nibble;
  logic                  dp_sel;
  logic [7:0]            seg_raw;
  logic [7:0]            seg_byte;
  logic [7:0]            dig_byte;

  // Free-running refresh divider; tick marks the last count of each period.
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // Byte sources. The digit-0 segment byte is loaded on the same edge that takes
  // the snapshot, so it reads the live inputs; every later byte of the frame
  // reads the snapshot.
  always_comb begin
    logic [4*N_DIGITS-1:0] value_shift;
    logic [N_DIGITS-1:0]   dp_shift;
    snap_now    = (state_q == ST_IDLE) && (digit_q == '0);
    value_src   = snap_now ? i_value   : value_q;
    dp_src      = snap_now ? i_dp_mask : dp_q;
    blank_src   = snap_now ? i_blank   : blank_q;
    value_shift = value_src >> {digit_q, 2'b00};
    dp_shift    = dp_src >> digit_q;
    nibble      = value_shift[3:0];
    dp_sel      = dp_shift[0];
    seg_byte    = COMMON_ANODE ? ~seg_raw : seg_raw;
    dig_byte    = COMMON_ANODE ? ~((8'h01 << digit_q) & DIG_MASK)
                               :  ((8'h01 << digit_q) & DIG_MASK);
  end

  hex_to_seg7 u_hex_to_seg7 (
    .i_nibble (nibble),
    .i_dp     (dp_sel),
    .i_blank  (blank_src),
    .o_seg    (seg_raw)
  );

  // Slot sequencer: start on tick or pending, strobe each byte, track rdy, advance digit.
  always_comb begin
    state_d      = state_q;
    byte_sel_d   = byte_sel_q;
    digit_d      = digit_q;
    pend_d       = pend_q;
    value_d      = value_q;
    dp_d         = dp_q;
    blank_d      = blank_q;
    data_d       = data_q;
    o_en         = 1'b0;
    o_frame_done = 1'b0;

    // One-deep memory of a tick that lands while a slot is in flight.
    if (tick && (state_q != ST_IDLE)) begin
      pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (tick || pend_q) begin
          pend_d     = 1'b0;
          byte_sel_d = 1'b0;
          data_d     = seg_byte;
          state_d    = ST_STROBE;
          if (digit_q == '0) begin
            value_d = i_value;
            dp_d    = i_dp_mask;
            blank_d = i_blank;
          end
        end
      end
      ST_STROBE: begin
        if (i_rdy) begin
          o_en    = 1'b1;
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (!i_rdy) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_rdy) begin
          if (!byte_sel_q) begin
            byte_sel_d = 1'b1;
            data_d     = dig_byte;
            state_d    = ST_STROBE;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        if (digit_q == DIG_LAST) begin
          digit_d      = '0;
          o_frame_done = 1'b1;
        end else begin
          digit_d = digit_q + 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any transfer in progress.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values regardless of statement order.
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      byte_sel_q <= 1'b0;
      digit_q    <= '0;
      div_q      <= '0;
      pend_q     <= 1'b0;
      value_q    <= '0;
      dp_q       <= '0;
      blank_q    <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      byte_sel_q <= byte_sel_d;
      digit_q    <= digit_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      value_q    <= value_d;
      dp_q       <= dp_d;
      blank_q    <= blank_d;
      data_q     <= data_d;
    end
  end

  assign o_data = data_q;
  assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seg7_scan_feeder.sv
// Directed bench for seg7_scan_feeder with a behavioural 595 driver model.
module tb_seg7_scan_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [15:0] value = 16'h12AF;
  logic [3:0] dp_mask = 4'b0000;
  logic       blank = 1'b0;

  logic [1:0] rdy = 2'b11;
  logic [1:0] en_w, busy_w, fd_w;
  logic [7:0] data0, data1;

  int         busy_len [2] = '{20, 20};
  int         cnt [2] = '{0, 0};
  logic [1:0] en_prev = 2'b00;

  int         cyc = 0;
  int         viol = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int         ecyc0 [$];
  int         fd_q0 [$];
  logic [7:0] last0 = 8'h00;
  logic [7:0] last1 = 8'h00;

  logic [7:0] exp_a [24] = '{
    8'h71, 8'h01, 8'h77, 8'h02, 8'h5B, 8'h04, 8'h06, 8'h08,
    8'h3F, 8'h01, 8'hBF, 8'h02, 8'h3F, 8'h04, 8'h3F, 8'h08,
    8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h08
  };
  logic [7:0] exp_ca [8] = '{
    8'h80, 8'hFE, 8'h80, 8'hFD, 8'h80, 8'hFB, 8'h80, 8'hF7
  };

  always #5 clk = ~clk;

  seg7_scan_feeder #(
    .N_DIGITS     (4),
    .REFRESH_DIV  (16),
    .COMMON_ANODE (1'b0)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_value      (value),
    .i_dp_mask    (dp_mask),
    .i_blank      (blank),
    .i_rdy        (rdy[0]),
    .o_data       (data0),
    .o_en         (en_w[0]),
    .o_frame_done (fd_w[0]),
    .o_busy       (busy_w[0])
  );

  seg7_scan_feeder #(
    .N_DIGITS     (4),
    .REFRESH_DIV  (16),
    .COMMON_ANODE (1'b1)
  ) dut_ca (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_value      (16'h8888),
    .i_dp_mask    (4'b0000),
    .i_blank      (1'b0),
    .i_rdy        (rdy[1]),
    .o_data       (data1),
    .o_en         (en_w[1]),
    .o_frame_done (fd_w[1]),
    .o_busy       (busy_w[1])
  );

  // Driver model: rdy drops the cycle after o_en and returns busy_len cycles later.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        rdy[i] = 1'b1;
        cnt[i] = 0;
      end else if (en_prev[i]) begin
        rdy[i] = 1'b0;
        cnt[i] = busy_len[i];
      end else if (cnt[i] > 0) begin
        cnt[i] = cnt[i] - 1;
        if (cnt[i] == 0) rdy[i] = 1'b1;
      end
    end
  end

  // Monitor: capture strobed bytes, frame pulses and handshake/stability violations.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      ecyc0.delete();
      fd_q0.delete();
      last0   = 8'h00;
      last1   = 8'h00;
      en_prev = 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (en_w[i] && (!rdy[i] || en_prev[i])) viol = viol + 1;
      end
      if (en_w[0]) begin
        q0.push_back(data0);
        ecyc0.push_back(cyc);
        last0 = data0;
      end else if (data0 !== last0) begin
        viol = viol + 1;
      end
      if (en_w[1]) begin
        q1.push_back(data1);
        last1 = data1;
      end else if (data1 !== last1) begin
        viol = viol + 1;
      end
      if (fd_w[0]) fd_q0.push_back(q0.size());
      en_prev = en_w;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int k;
    k = 0;
    while (q0.size() < n && k < 3000) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (q0.size() < n) check(tag, q0.size(), n);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    int base;
    int idx_a;
    int gap_ab;
    int gap_bd;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", data0, 8'h00);
    check("rst_en", en_w[0], 1'b0);
    check("rst_busy", busy_w[0], 1'b0);
    check("rst_frame_done", fd_w[0], 1'b0);
    check("rst_data_ca", data1, 8'h00);

    // Release and measure the first strobe.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!en_w[0] && n < 100);
    check("first_en_cycle", n, 17);

    // Frame 1 shows 12AF even though inputs change after its first slot.
    wait_bytes(2, "frame1_start");
    value   = 16'h0000;
    dp_mask = 4'b0010;
    // Blank arrives mid frame 2; frame 2 keeps its snapshot.
    wait_bytes(10, "frame2_start");
    blank = 1'b1;
    // Frame 3 has snapshotted blank; release it for later frames.
    wait_bytes(18, "frame3_start");
    blank = 1'b0;
    wait_bytes(24, "frame3_end");
    k = 0;
    while (fd_q0.size() < 3 && k < 500) begin
      @(negedge clk);
      #1;
      k++;
    end

    for (int i = 0; i < 24; i++) begin
      check($sformatf("byte%0d", i), q0[i], exp_a[i]);
    end
    check("frame_done_count", fd_q0.size(), 3);
    for (int i = 0; i < fd_q0.size() && i < 3; i++) begin
      check($sformatf("frame_done_at%0d", i), fd_q0[i], 8 * (i + 1));
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ca_byte%0d", i), q1[i], exp_ca[i]);
    end

    // Reset while waiting for the driver to finish a digit byte.
    wait_bytes(26, "frame4_digit0");
    repeat (5) @(negedge clk);
    check("pre_rst_data", data0, 8'h01);
    check("pre_rst_busy", busy_w[0], 1'b1);
    check("pre_rst_rdy", rdy[0], 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", en_w[0], 1'b0);
    check("mid_rst_busy", busy_w[0], 1'b0);
    check("mid_rst_data", data0, 8'h00);
    repeat (3) @(posedge clk);
    value   = 16'h4321;
    dp_mask = 4'b0000;
    blank   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_bytes(2, "post_rst");
    check("post_rst_seg", q0[0], 8'h06);
    check("post_rst_digit", q0[1], 8'h01);

    // Fast driver, then one slot whose segment byte keeps the driver busy 60 cycles.
    busy_len[0] = 1;
    wait_bytes(q0.size() + 6, "fast_settle");
    base = q0.size();
    k = 0;
    while (!(q0.size() > base && (q0.size() % 2) == 0) && k < 500) begin
      @(negedge clk);
      #1;
      k++;
    end
    @(posedge clk);
    #2;
    busy_len[0] = 60;
    idx_a = q0.size();
    wait_bytes(idx_a + 1, "slot_a");
    @(posedge clk);
    #2;
    busy_len[0] = 1;
    wait_bytes(idx_a + 7, "slot_d");
    gap_ab = ecyc0[idx_a + 2] - ecyc0[idx_a];
    gap_bd = ecyc0[idx_a + 6] - ecyc0[idx_a + 2];
    check("pending_gap_ab", gap_ab, 67);
    check("pending_one_deep", (gap_bd >= 17 && gap_bd <= 32), 1'b1);

    check("protocol_violations", viol, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
